pipe_stage_skid_reg: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed datapath bus and one packed control bus between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and throughput is one beat per cycle under backpressure.
- Supports stage flush and bubble insertion with control fields forced to zero, so RegWrite/MemWrite never fire on a bubble.

---
 rtl/pipe_stage_skid_reg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: generic inter-stage pipeline register with a
// valid/ready handshake and a 2-entry skid buffer. in_ready is registered,
// and the stage still moves one beat per cycle under backpressure.
// Flush and bubbles force the control bus to zero, so a dead slot can never
// fire RegWrite/MemWrite downstream.
// Optional build macro: PIPE_STATS_EN adds the saturating stall_cnt and
// bubble_cnt statistics counters. Without it, both ports are tied to 0.
//
// state | meaning
// ------+---------------------------------------
// EMPTY | no beat held, out_valid=0
// BUSY  | main holds a beat, skid empty
// FULL  | main and skid both hold beats, in_ready=0
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // Next-state and register-load decode; flush overrides the handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      // Data registers are left alone so the datapath does not toggle.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = FULL;
          end else if (out_fire) begin
            main_ctrl_d = '0;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = BUSY;
          end
        end
        default: begin
          main_ctrl_d = '0;
          state_d     = EMPTY;
        end
      endcase
    end
    // Register in_ready from the next state so it carries no combinational
    // path from out_ready.
    in_ready_d = (state_d != FULL);
  end

  // State, handshake and payload registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating per-cycle stall and bubble counts; flush does not clear them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
